// File: rtl/div_unit_pkg.sv
// Shared widths, state encodings and helpers for the multi-cycle divider.
package div_unit_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned DREG_W = 64;
  localparam int unsigned CNT_W  = 6;

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  localparam logic [CNT_W-1:0] DIV_ITERS = CNT_W'(REG_W);
  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  // Magnitude of a signed operand; 0x80000000 maps to itself as unsigned 2^31.
  function automatic logic [REG_W-1:0] abs_op(input logic is_signed, input logic [REG_W-1:0] v);
    return (is_signed && v[REG_W-1]) ? (~v + REG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage and the divider.
interface div_unit_if;
  import div_unit_pkg::*;

  logic              signed_div_i;
  logic [REG_W-1:0]  opdata1_i;
  logic [REG_W-1:0]  opdata2_i;
  logic              start_i;
  logic              annul_i;
  logic [DREG_W-1:0] result_o;
  logic              ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// divide-by-zero short path, sign correction and flush cancellation.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  logic [1:0]        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [DREG_W-1:0] work_q, work_n;
  logic [REG_W-1:0]  divisor_q, divisor_n;
  logic              sign_a_q, sign_a_n;
  logic              sign_b_q, sign_b_n;
  logic              signed_q, signed_n;
  logic [DREG_W-1:0] result_q, result_n;
  logic              ready_q, ready_n;

  // Iteration datapath: shifted {rem, quo}, trial compare and difference.
  logic [DREG_W:0]   shifted;
  logic              trial_ge;
  logic [REG_W-1:0]  trial_diff;
  logic [REG_W-1:0]  quo_fix, rem_fix;

  assign shifted    = {work_q, 1'b0};
  assign trial_ge   = shifted[DREG_W:REG_W] >= {1'b0, divisor_q};
  assign trial_diff = shifted[DREG_W-1:REG_W] - divisor_q;
  assign quo_fix    = (signed_q && (sign_a_q ^ sign_b_q)) ? (~work_q[REG_W-1:0] + REG_W'(1))
                                                          : work_q[REG_W-1:0];
  assign rem_fix    = (signed_q && sign_a_q) ? (~work_q[DREG_W-1:REG_W] + REG_W'(1))
                                             : work_q[DREG_W-1:REG_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      work_q    <= work_n;
      divisor_q <= divisor_n;
      sign_a_q  <= sign_a_n;
      sign_b_q  <= sign_b_n;
      signed_q  <= signed_n;
      result_q  <= result_n;
      ready_q   <= ready_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    work_n    = work_q;
    divisor_n = divisor_q;
    sign_a_n  = sign_a_q;
    sign_b_n  = sign_b_q;
    signed_n  = signed_q;
    result_n  = result_q;
    ready_n   = ready_q;

    case (state_q)
      DIV_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == ZERO_WORD) begin
            state_n = DIV_BY_ZERO;
          end else begin
            state_n   = DIV_ON;
            cnt_n     = '0;
            work_n    = {ZERO_WORD, abs_op(bus.signed_div_i, bus.opdata1_i)};
            divisor_n = abs_op(bus.signed_div_i, bus.opdata2_i);
            sign_a_n  = bus.opdata1_i[REG_W-1];
            sign_b_n  = bus.opdata2_i[REG_W-1];
            signed_n  = bus.signed_div_i;
          end
        end
      end
      DIV_BY_ZERO: begin
        state_n  = DIV_END;
        result_n = '0;
        ready_n  = 1'b1;
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          state_n  = DIV_FREE;
          cnt_n    = '0;
          result_n = '0;
          ready_n  = 1'b0;
        end else if (cnt_q != DIV_ITERS) begin
          // Remainder below the divisor guarantees shifted[64] is clear on the restore path.
          work_n = trial_ge ? {trial_diff, shifted[REG_W-1:1], 1'b1} : shifted[DREG_W-1:0];
          cnt_n  = cnt_q + CNT_W'(1);
        end else begin
          state_n  = DIV_END;
          result_n = {rem_fix, quo_fix};
          ready_n  = 1'b1;
        end
      end
      DIV_END: begin
        if (!bus.start_i) begin
          state_n  = DIV_FREE;
          result_n = '0;
          ready_n  = 1'b0;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus randomized operands.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [63:0] sb_q[$];

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  // One full request: accept, measure latency, compare, hold, release.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [63:0] exp, input string tag);
    int lat;
    logic [63:0] want;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = 1'($urandom_range(1));
    lat = 0;
    while (!bus.ready_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
    want = sb_q.pop_front();
    check_eq({tag, "_result"}, bus.result_o, want);
    repeat (hold) @(posedge clk);
    #1;
    check_eq({tag, "_hold"}, {bus.result_o[62:0], bus.ready_o}, {want[62:0], 1'b1});
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_release"}, {bus.result_o, 63'd0, bus.ready_o}, 128'd0);
  endtask

  initial begin
    int hi;
    logic sgn;
    logic [31:0] a, b;

    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #3;
    check_eq("reset_out", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 2, 64'h00000002_0000000E, "divu_100_7");
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 1, 64'h00000001_FFFFFFFD, "div_7_m2");
    run_div(1'b0, 32'hFFFFFFF9, 32'd2, 0, 64'h00000001_7FFFFFFC, "divu_big_2");
    run_div(1'b1, 32'd5, 32'd0, 1, 64'd0, "div_by_zero");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 64'h00000000_80000000, "div_overflow");

    // Flush at E10 must drop the request without a result.
    @(negedge clk);
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    hi = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) hi++;
    end
    check_eq("annul_no_ready", 64'(hi), 64'd0);
    run_div(1'b1, 32'd1000, 32'd3, 1, 64'h00000001_0000014D, "annul_retry");

    // Async reset in the middle of a division.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd12345;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_div", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst = 1'b0;
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0, 64'h00000000_FFFFFFFF, "after_rst");

    // Async reset while a result is being held.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    check_eq("rst_pre_ready", {bus.result_o, bus.ready_o}, {64'h00000002_0000000E, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_in_end", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      sgn = 1'($urandom_range(1));
      a   = $urandom;
      if ($urandom_range(15) == 0) a = 32'h80000000;
      case ($urandom_range(7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, $urandom_range(2), ref_div(sgn, a, b), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
